mem_rmw_ctrl: RTL
=================

MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, which sets the address width; the data width SHALL be fixed at 32.
REQ-002 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n_i  input  1  asynchronous, active-low reset.
REQ-004 req_valid_i  input  1  request valid.
REQ-005 req_ready_o  output  1  request accepted on valid&ready.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_addr_i  input  ADDR_WIDTH  byte address.
REQ-008 req_wdata_i  input  32  store data, LSB-aligned.
REQ-009 req_type_i  input  2  01 = byte, 10 = half; any other value = word.
REQ-010 rsp_valid_o  output  1  response valid; held until rsp_ready_i.
REQ-011 rsp_ready_i  input  1  requester accepts the response.
REQ-012 rsp_rdata_o  output  32  raw memory word (loads); 0 for stores.
REQ-013 rsp_err_o  output  1  misaligned-access flag, qualified by rsp_valid_o.
REQ-014 mem_en_o  output  1  memory access strobe.
REQ-015 mem_we_o  output  1  memory write enable.
REQ-016 mem_addr_o  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 00.
REQ-017 mem_wdata_o  output  32  full word to be written.
REQ-018 mem_rdata_i  input  32  read data, valid one cycle after a read strobe.
REQ-019 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 The FSM states SHALL be IDLE, RD, WAIT, WR and RSP; req_ready_o SHALL be 1 only in IDLE.
REQ-021 On acceptance, the block SHALL capture we, addr, wdata and type into registers; request inputs SHALL be ignored outside IDLE.
REQ-022 For a word store, the FSM SHALL follow IDLE->WR->RSP.
REQ-023 For a byte or half store, the FSM SHALL follow IDLE->RD->WAIT->WR->RSP.
REQ-024 For a load of any type, the FSM SHALL follow IDLE->RD->WAIT->RSP.
REQ-025 In RD, the block SHALL drive mem_en_o=1, mem_we_o=0 and mem_addr_o = {addr[ADDR_WIDTH-1:2],2'b00} for exactly one cycle.
REQ-026 In WAIT, the block SHALL drive no memory strobe and SHALL register mem_rdata_i into a word buffer.
REQ-027 In WR, the block SHALL drive mem_en_o=1, mem_we_o=1 and mem_wdata_o = the merged word for exactly one cycle.
REQ-028 Byte merge: for k = addr[1:0], bits [8k+7:8k] of the buffer SHALL be replaced by wdata[7:0] and all other bits preserved.
REQ-029 Half merge: if addr[1]=1, buffer bits [31:16] SHALL be replaced by wdata[15:0]; otherwise bits [15:0] SHALL be replaced; the other half SHALL be preserved.
REQ-030 Word store: mem_wdata_o SHALL equal wdata unchanged.
REQ-031 In RSP, rsp_valid_o SHALL be 1 and SHALL remain 1 until rsp_ready_i=1; the FSM SHALL then return to IDLE on that edge.
REQ-032 rsp_rdata_o SHALL equal the buffer for loads and 0 for stores.
REQ-033 Back-to-back operation: a new request SHALL be accepted no earlier than the cycle after the response handshake completes.
REQ-034 Minimum latency from acceptance edge to rsp_valid_o: word store 2 cycles, sub-word store 4 cycles, load 3 cycles.
REQ-035 mem_en_o, mem_we_o and mem_wdata_o SHALL be 0 in all states other than RD and WR.

Reset
REQ-036 When rst_n_i=0, the block SHALL immediately enter IDLE and clear all registers to 0, independent of clk_i.
REQ-037 During reset, outputs SHALL be: req_ready_o=1, busy_o=0, rsp_valid_o=0, rsp_err_o=0, and all mem_* outputs 0.
REQ-038 Reset asserted mid-operation, including in WR, SHALL abort the operation with no further memory write and no response.

Configuration
REQ-039 Macro RMW_MISALIGN_CHK_EN SHALL gate the misalignment check.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=00, SHALL go IDLE->RSP directly with rsp_err_o=1, no memory access and rsp_rdata_o=0.
- Undefined: rsp_err_o SHALL be tied to 0. Half accesses SHALL use only addr[1]; word accesses SHALL ignore addr[1:0].

Verification
REQ-040 Byte store: memory word 0x11223344 at 0x100; store byte 0xAB to 0x102 -> one read, then a write of 0x11AB3344; rsp_valid_o asserted 4 cycles after acceptance.
REQ-041 Half store: word 0xDEADBEEF at 0x200; store half 0x1234 to 0x202 -> write 0x1234BEEF; store 0x5678 to 0x200 -> write 0x12345678.
REQ-042 Word store: store 0xCAFEF00D to 0x300 -> no read strobe, one write of 0xCAFEF00D, rsp_valid_o 2 cycles after acceptance.
REQ-043 Load with backpressure: load from 0x104 holding 0x0BADF00D, with rsp_ready_i held 0 for 3 cycles -> rsp_valid_o and rsp_rdata_o=0x0BADF00D held stable for 3 cycles, and req_ready_o=0 throughout.
REQ-044 Reset mid-operation: assert rst_n_i=0 while in WAIT of a byte store -> outputs reach reset values with no clock edge, no write is issued, and memory is unchanged.
REQ-045 Misaligned half access to 0x101 -> with RMW_MISALIGN_CHK_EN defined: rsp_err_o=1 and zero memory strobes; without the macro: a read-merge-write of bits [15:0].

Source files
------------

// File: rtl/mem_rmw_ctrl.sv
// mem_rmw_ctrl: read-modify-write front end for a 32-bit word memory.
// Byte and half stores are turned into a word read, a merge and a word write.
// Word stores go straight to a write, and loads return the raw word.
// Optional macro RMW_MISALIGN_CHK_EN: misaligned half and word requests are
// answered with an error and never reach memory.
`timescale 1ns/1ps
module mem_rmw_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [1:0]            req_type_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RSP} state_e;

  localparam logic [1:0] T_BYTE = 2'b01;
  localparam logic [1:0] T_HALF = 2'b10;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            type_q, type_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           merged;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  in_word;
  logic                  mis_in;

  // Anything that is not byte or half is treated as a word access.
  assign in_word   = (req_type_i != T_BYTE) && (req_type_i != T_HALF);
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

`ifdef RMW_MISALIGN_CHK_EN
  logic err_q, err_d;
  assign mis_in    = ((req_type_i == T_HALF) && req_addr_i[0]) ||
                     (in_word && (req_addr_i[1:0] != 2'b00));
  assign rsp_err_o = (state_q == RSP) && err_q;
`else
  assign mis_in    = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // Merge captured store data into the word read back from memory.
  always_comb begin
    merged = buf_q;
    if (type_q == T_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (type_q == T_HALF) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged = wdata_q;
    end
  end

  // State and request/buffer registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= '0;
      buf_q   <= '0;
`ifdef RMW_MISALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      buf_q   <= buf_d;
`ifdef RMW_MISALIGN_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next state, captures and all outputs decoded from the current state.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    type_d      = type_q;
    buf_d       = buf_q;
`ifdef RMW_MISALIGN_CHK_EN
    err_d       = err_q;
`endif
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          type_d  = req_type_i;
          // Cleared so an error or store response never shows a stale load.
          buf_d   = '0;
`ifdef RMW_MISALIGN_CHK_EN
          err_d   = mis_in;
`endif
          if (mis_in)                  state_d = RSP;
          else if (req_we_i && in_word) state_d = WR;
          else                          state_d = RD;
        end
      end
      RD: begin
        mem_en_o   = 1'b1;
        mem_addr_o = word_addr;
        state_d    = WAIT;
      end
      WAIT: begin
        buf_d   = mem_rdata_i;
        state_d = we_q ? WR : RSP;
      end
      WR: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = word_addr;
        mem_wdata_o = merged;
        state_d     = RSP;
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata_o = ((state_q == RSP) && !we_q) ? buf_q : 32'h0;
  assign busy_o      = (state_q != IDLE);

endmodule
